except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl.sv | 115 +++++++++++
 tb/tb_except_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: picks the highest-priority exception, redirects the PC,
// and produces a one-cycle pipeline flush along with the registered CP0 update fields.
module except_ctrl #(
  parameter logic [31:0] EBASE_OFS = 32'h00000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [31:0] CODE_NONE    = 32'h0;
  localparam logic [31:0] CODE_INT     = 32'h1;
  localparam logic [31:0] CODE_SYSCALL = 32'h8;
  localparam logic [31:0] CODE_INVALID = 32'ha;
  localparam logic [31:0] CODE_TRAP    = 32'hd;
  localparam logic [31:0] CODE_OVF     = 32'hc;
  localparam logic [31:0] CODE_ERET    = 32'he;

  state_t      state, state_next;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_pending, detect;
  logic [31:0] code;
  logic [31:0] excepttype_next, addr_next, new_pc_next;
  logic        delayslot_next, flush_next;
  logic        unused_bits;

  // Forward a CP0 write still sitting in WB so this cycle's decision sees it.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) eff_status = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) eff_cause[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) eff_epc = wb_cp0_data_i;
  end

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  assign int_pending = ((eff_cause[15:8] & eff_status[15:8]) != 8'h00) &&
                       !eff_status[1] && eff_status[0];

  assign detect = (state == IDLE) && valid_i && !stall_i &&
                  (int_pending || (exc_flags_i != 5'b00000));

  always_comb begin
    code = CODE_NONE;
    if (int_pending)         code = CODE_INT;
    else if (exc_flags_i[4]) code = CODE_SYSCALL;
    else if (exc_flags_i[3]) code = CODE_INVALID;
    else if (exc_flags_i[2]) code = CODE_TRAP;
    else if (exc_flags_i[1]) code = CODE_OVF;
    else if (exc_flags_i[0]) code = CODE_ERET;
  end

  // FLUSH lasts exactly one cycle and ignores every input, stall included.
  always_comb begin
    state_next      = state;
    excepttype_next = CODE_NONE;
    flush_next      = 1'b0;
    addr_next       = current_inst_addr_o;
    delayslot_next  = is_in_delayslot_o;
    new_pc_next     = new_pc_o;
    case (state)
      IDLE: begin
        addr_next      = inst_addr_i;
        delayslot_next = is_in_delayslot_i;
        if (detect) begin
          excepttype_next = code;
          flush_next      = 1'b1;
          new_pc_next     = (code == CODE_ERET) ? eff_epc : (cp0_ebase_i + EBASE_OFS);
          state_next      = FLUSH;
        end
      end
      FLUSH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      excepttype_o        <= CODE_NONE;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
    end else begin
      state               <= state_next;
      excepttype_o        <= excepttype_next;
      current_inst_addr_o <= addr_next;
      is_in_delayslot_o   <= delayslot_next;
      flush_o             <= flush_next;
      new_pc_o            <= new_pc_next;
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl; expected values are hand-computed.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  exc_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] F_SYS = 5'b10000, F_INV = 5'b01000, F_TRAP = 5'b00100,
                         F_OVF = 5'b00010, F_ERET = 5'b00001;

  except_ctrl #(.EBASE_OFS(32'h00000180)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i),
    .inst_addr_i(inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .exc_flags_i(exc_flags_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_exc(input string tag, input logic [31:0] code, input logic [31:0] pc);
    check({tag, ".flush"}, {31'b0, flush_o}, 32'h1);
    check({tag, ".type"}, excepttype_o, code);
    check({tag, ".new_pc"}, new_pc_o, pc);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".flush"}, {31'b0, flush_o}, 32'h0);
    check({tag, ".type"}, excepttype_o, 32'h0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; stall_i = 1'b0; inst_addr_i = 32'h0;
    is_in_delayslot_i = 1'b0; exc_flags_i = 5'b0; cp0_status_i = 32'h0;
    cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; cp0_ebase_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;

    // Reset state
    step(); step();
    check_quiet("reset");
    check("reset.addr", current_inst_addr_o, 32'h0);
    check("reset.ds", {31'b0, is_in_delayslot_o}, 32'h0);
    check("reset.new_pc", new_pc_o, 32'h0);

    // Idle pass-through of address and delay-slot flag
    rst = 1'b0; valid_i = 1'b1; inst_addr_i = 32'h00001234; is_in_delayslot_i = 1'b1;
    step();
    check_quiet("idle");
    check("idle.addr", current_inst_addr_o, 32'h00001234);
    check("idle.ds", {31'b0, is_in_delayslot_o}, 32'h1);
    check("idle.new_pc", new_pc_o, 32'h0);

    // Syscall
    exc_flags_i = F_SYS; inst_addr_i = 32'h80000100; is_in_delayslot_i = 1'b0;
    cp0_ebase_i = 32'h80000000;
    step();
    check_exc("syscall", 32'h8, 32'h80000180);
    check("syscall.addr", current_inst_addr_o, 32'h80000100);
    check("syscall.ds", {31'b0, is_in_delayslot_o}, 32'h0);
    exc_flags_i = 5'b0;
    step();
    check_quiet("syscall.end");

    // ERET with EPC forwarded from WB
    exc_flags_i = F_ERET; cp0_epc_i = 32'h00001000;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h00002000;
    step();
    check_exc("eret_fwd", 32'he, 32'h00002000);
    exc_flags_i = 5'b0; wb_cp0_we_i = 1'b0;
    step();
    check_quiet("eret_fwd.end");

    // ERET with plain EPC
    exc_flags_i = F_ERET;
    step();
    check_exc("eret", 32'he, 32'h00001000);
    exc_flags_i = 5'b0;
    step();

    // Interrupt pending but no valid instruction
    valid_i = 1'b0; cp0_status_i = 32'h00000401; cp0_cause_i = 32'h00000400;
    step();
    check_quiet("int_novalid");

    // Interrupt beats overflow
    valid_i = 1'b1; exc_flags_i = F_OVF;
    step();
    check_exc("int_over_ovf", 32'h1, 32'h80000180);
    exc_flags_i = 5'b0; cp0_status_i = 32'h0;
    step();

    // EXL set masks the interrupt, overflow wins
    cp0_status_i = 32'h00000403; exc_flags_i = F_OVF;
    step();
    check_exc("ovf_exl", 32'hc, 32'h80000180);
    exc_flags_i = 5'b0; cp0_status_i = 32'h0;
    step();
    check_quiet("ovf_exl.end");

    // Interrupt enabled only via forwarded status write
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h00000401;
    step();
    check_exc("int_status_fwd", 32'h1, 32'h80000180);
    wb_cp0_we_i = 1'b0; cp0_cause_i = 32'h0;
    step();

    // Interrupt raised only via forwarded cause software bit
    cp0_status_i = 32'h00000101;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h00000100;
    step();
    check_exc("int_cause_fwd", 32'h1, 32'h80000180);
    wb_cp0_we_i = 1'b0; cp0_status_i = 32'h0;
    step();

    // Priority among synchronous exceptions
    exc_flags_i = F_SYS | F_INV | F_TRAP;
    step();
    check("prio_sys.type", excepttype_o, 32'h8);
    exc_flags_i = 5'b0;
    step();
    exc_flags_i = F_INV | F_TRAP | F_OVF | F_ERET;
    step();
    check("prio_inv.type", excepttype_o, 32'ha);
    exc_flags_i = 5'b0;
    step();

    // EBase + offset wraps at 32 bits
    cp0_ebase_i = 32'hFFFFFF00; exc_flags_i = F_OVF;
    step();
    check_exc("wrap", 32'hc, 32'h00000080);
    exc_flags_i = 5'b0; cp0_ebase_i = 32'h80000000;
    step();

    // Trap held off by a 3-cycle stall, then stall during FLUSH has no effect
    exc_flags_i = F_TRAP; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("trap_stall%0d.flush", i), {31'b0, flush_o}, 32'h0);
    end
    stall_i = 1'b0;
    step();
    check_exc("trap", 32'hd, 32'h80000180);
    exc_flags_i = 5'b0; stall_i = 1'b1;
    step();
    check_quiet("trap.stall_in_flush");
    stall_i = 1'b0;
    step();

    // Back-to-back syscall: second one falls in FLUSH and is ignored
    exc_flags_i = F_SYS;
    step();
    check_exc("b2b", 32'h8, 32'h80000180);
    step();
    check_quiet("b2b.second");
    exc_flags_i = 5'b0;
    step();
    check_quiet("b2b.after");

    // Reset during FLUSH aborts it
    exc_flags_i = F_SYS; inst_addr_i = 32'h00004444; is_in_delayslot_i = 1'b1;
    step();
    check_exc("rst_flush", 32'h8, 32'h80000180);
    rst = 1'b1; exc_flags_i = 5'b0;
    step();
    check_quiet("rst_flush.abort");
    check("rst_flush.addr", current_inst_addr_o, 32'h0);
    check("rst_flush.ds", {31'b0, is_in_delayslot_o}, 32'h0);
    check("rst_flush.new_pc", new_pc_o, 32'h0);
    rst = 1'b0;
    step();
    check_quiet("rst_flush.idle");
    exc_flags_i = F_TRAP;
    step();
    check_exc("rst_flush.redetect", 32'hd, 32'h80000180);
    exc_flags_i = 5'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
